// File: rtl/keypad_entry_pkg.sv
// Shared FSM state codes, key codes and key classification helpers
// for the keypad operand entry block.
package keypad_entry_pkg;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        DONE    = 2'd2
    } entry_state_t;

    localparam logic [1:0] ST_CODE_INVALID = 2'd3;

    localparam logic [3:0] KEY_PLUS   = 4'hA;
    localparam logic [3:0] KEY_MINUS  = 4'hB;
    localparam logic [3:0] KEY_CLEAR  = 4'hC;
    localparam logic [3:0] KEY_BACK   = 4'hD;
    localparam logic [3:0] KEY_EQUALS = 4'hE;
    localparam logic [3:0] KEY_NONE   = 4'hF;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'h9);
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k == KEY_PLUS) || (k == KEY_MINUS);
    endfunction

endpackage

// File: rtl/keypad_operand_entry_key_debounce.sv
// Turns a held key into a single one-cycle strobe plus its code.
// KEYPAD_DEBOUNCE_EN selects a stable-count filter; otherwise a plain rising-edge detect.
module key_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_key_value,
    input  logic       i_key_valid,
    output logic       o_strobe,
    output logic [3:0] o_code
);

    logic       r_valid_q;
    logic       r_level;
    logic [3:0] r_code_q;
    logic       w_accept;

    // Reset treats the key as already down, so a key held through reset must be released first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= 1'b1;
            r_code_q  <= 4'h0;
        end else begin
            r_valid_q <= i_key_valid;
            r_code_q  <= i_key_value;
        end
    end

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_settled;

    assign w_settled = (r_cnt == CW'(DEBOUNCE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else if (r_valid_q == r_level) begin
            r_cnt <= '0;
        end else if (w_settled) begin
            r_cnt   <= '0;
            r_level <= r_valid_q;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_accept = r_valid_q & ~r_level & w_settled;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b1;
        end else begin
            r_level <= r_valid_q;
        end
    end

    assign w_accept = r_valid_q & ~r_level;
`endif

    assign o_strobe = w_accept;
    assign o_code   = r_code_q;

endmodule

// File: rtl/keypad_operand_entry.sv
// Hex keypad entry of two operands and an add/sub request; results update one clock after a key is accepted.
// Debounce filtering is enabled by defining KEYPAD_DEBOUNCE_EN.
module keypad_operand_entry
    import keypad_entry_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DEBOUNCE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            key_value,
    input  logic                  key_valid,
    output logic [DIGITS*4-1:0]   operand_a,
    output logic [DIGITS*4-1:0]   operand_b,
    output logic                  sub,
    output logic                  go,
    output logic [DIGITS*4-1:0]   display,
    output logic [1:0]            entry_state
);

    localparam int W  = DIGITS * 4;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    logic          w_strobe;
    logic [3:0]    w_code;
    logic          w_digit;
    logic          w_op;
    logic [W-1:0]  w_nib;

    entry_state_t  r_state;
    logic [W-1:0]  r_op_a;
    logic [W-1:0]  r_op_b;
    logic [CW-1:0] r_cnt_a;
    logic [CW-1:0] r_cnt_b;
    logic          r_sub;
    logic          r_go;

    key_debounce #(
        .DEBOUNCE    (DEBOUNCE)
    ) u_key_debounce (
        .clk         (clk),
        .rst_n       (reset),
        .i_key_value (key_value),
        .i_key_valid (key_valid),
        .o_strobe    (w_strobe),
        .o_code      (w_code)
    );

    assign w_digit = is_digit(w_code);
    assign w_op    = is_op(w_code);
    assign w_nib   = W'(w_code);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ENTER_A;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_sub   <= 1'b0;
            r_go    <= 1'b0;
        end else begin
            r_go <= 1'b0;
            if (w_strobe && w_code == KEY_CLEAR) begin
                r_state <= ENTER_A;
                r_op_a  <= '0;
                r_op_b  <= '0;
                r_cnt_a <= '0;
                r_cnt_b <= '0;
                r_sub   <= 1'b0;
            end else begin
                case (r_state)
                    ENTER_A: if (w_strobe) begin
                        if (w_digit && r_cnt_a != FULL) begin
                            r_op_a  <= (r_op_a << 4) | w_nib;
                            r_cnt_a <= r_cnt_a + CW'(1);
                        end else if (w_code == KEY_BACK && r_cnt_a != '0) begin
                            r_op_a  <= r_op_a >> 4;
                            r_cnt_a <= r_cnt_a - CW'(1);
                        end else if (w_op) begin
                            r_sub   <= (w_code == KEY_MINUS);
                            r_op_b  <= '0;
                            r_cnt_b <= '0;
                            r_state <= ENTER_B;
                        end
                    end
                    ENTER_B: if (w_strobe) begin
                        if (w_digit && r_cnt_b != FULL) begin
                            r_op_b  <= (r_op_b << 4) | w_nib;
                            r_cnt_b <= r_cnt_b + CW'(1);
                        end else if (w_code == KEY_BACK && r_cnt_b != '0) begin
                            r_op_b  <= r_op_b >> 4;
                            r_cnt_b <= r_cnt_b - CW'(1);
                        end else if (w_op) begin
                            r_sub <= (w_code == KEY_MINUS);
                        end else if (w_code == KEY_EQUALS) begin
                            r_go    <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                    // A digit after a result starts a fresh calculation; an operator chains on operand_a.
                    DONE: if (w_strobe) begin
                        if (w_digit) begin
                            r_op_a  <= w_nib;
                            r_cnt_a <= CW'(1);
                            r_op_b  <= '0;
                            r_cnt_b <= '0;
                            r_state <= ENTER_A;
                        end else if (w_op) begin
                            r_sub   <= (w_code == KEY_MINUS);
                            r_op_b  <= '0;
                            r_cnt_b <= '0;
                            r_state <= ENTER_B;
                        end
                    end
                    default: r_state <= ENTER_A;
                endcase
            end
        end
    end

    assign operand_a   = r_op_a;
    assign operand_b   = r_op_b;
    assign sub         = r_sub;
    assign go          = r_go;
    assign display     = (r_state == ENTER_A) ? r_op_a : r_op_b;
    assign entry_state = r_state;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Randomized and directed bench for keypad_operand_entry against a behavioural entry model.
module tb_keypad_operand_entry;

    localparam int DIG = 4;
    localparam int DEB = 16;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int N = DEB;
`else
    localparam int N = 1;
`endif
    localparam int HOLD = N + 2;
    localparam int GAP  = N + 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  key_value;
    logic        key_valid;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic        sub;
    logic        go;
    logic [15:0] display;
    logic [1:0]  entry_state;

    keypad_operand_entry #(.DIGITS(DIG), .DEBOUNCE(DEB)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .key_value   (key_value),
        .key_valid   (key_valid),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .sub         (sub),
        .go          (go),
        .display     (display),
        .entry_state (entry_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int go_seen  = 0;
    int sub_at_go = -1;
    bit started  = 0;

    // Model: operand values as plain integers, state 0=A 1=B 2=done.
    int m_a, m_b, m_ca, m_cb, m_sub, m_go, m_st;
    // Key acceptance: a press counts once the input has differed from the
    // current key level for N consecutive samples; applied one clock later.
    int       m_run;
    bit       m_down;
    bit       m_pend;
    bit [3:0] m_pend_key;

    task automatic cmp(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void apply(input bit [3:0] k);
        if (k == 4'hC) begin
            m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_sub = 0; m_st = 0;
        end else if (m_st == 2) begin
            if (k <= 4'h9) begin
                m_a = k; m_ca = 1; m_b = 0; m_cb = 0; m_st = 0;
            end else if (k == 4'hA || k == 4'hB) begin
                m_b = 0; m_cb = 0; m_sub = (k == 4'hB); m_st = 1;
            end
        end else if (k <= 4'h9) begin
            if (m_st == 0 && m_ca < DIG) begin m_a = m_a * 16 + k; m_ca++; end
            if (m_st == 1 && m_cb < DIG) begin m_b = m_b * 16 + k; m_cb++; end
        end else if (k == 4'hD) begin
            if (m_st == 0 && m_ca > 0) begin m_a = m_a / 16; m_ca--; end
            if (m_st == 1 && m_cb > 0) begin m_b = m_b / 16; m_cb--; end
        end else if (k == 4'hA || k == 4'hB) begin
            m_sub = (k == 4'hB);
            if (m_st == 0) begin m_b = 0; m_cb = 0; m_st = 1; end
        end else if (k == 4'hE && m_st == 1) begin
            m_go = 1; m_st = 2;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_sub = 0; m_go = 0; m_st = 0;
            m_run = 0; m_down = 1'b1; m_pend = 1'b0; m_pend_key = 4'h0;
        end else begin
            m_go = 0;
            if (m_pend) begin
                apply(m_pend_key);
                m_pend = 1'b0;
            end
            if (key_valid != m_down) begin
                m_run++;
                if (m_run == N) begin
                    m_down = key_valid;
                    m_run  = 0;
                    if (key_valid) begin
                        m_pend     = 1'b1;
                        m_pend_key = key_value;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            cmp("operand_a", int'(operand_a), m_a);
            cmp("operand_b", int'(operand_b), m_b);
            cmp("sub", int'(sub), m_sub);
            cmp("go", int'(go), m_go);
            cmp("display", int'(display), (m_st == 0) ? m_a : m_b);
            cmp("entry_state", int'(entry_state), m_st);
            if (go) begin
                go_seen++;
                sub_at_go = int'(sub);
            end
        end
    end

    task automatic press(input bit [3:0] k, input int hold, input int gap);
        @(negedge clk);
        key_value = k;
        key_valid = 1'b1;
        repeat (hold) @(negedge clk);
        key_valid = 1'b0;
        key_value = 4'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic keys(input bit [3:0] seq[$]);
        foreach (seq[i]) press(seq[i], HOLD, GAP);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_value = 4'h0;
        #1 started = 1;
        repeat (3) @(negedge clk);
        cmp("reset operand_a", int'(operand_a), 0);
        cmp("reset entry_state", int'(entry_state), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1,2,+,3,=
        keys('{4'hC, 4'h1, 4'h2});
        go_seen = 0;
        keys('{4'hA, 4'h3, 4'hE});
        cmp("seq1 operand_a", int'(operand_a), 'h0012);
        cmp("seq1 operand_b", int'(operand_b), 'h0003);
        cmp("seq1 sub", int'(sub), 0);
        cmp("seq1 state", int'(entry_state), 2);
        cmp("seq1 go pulses", go_seen, 1);

        // Overflow digit ignored, then backspace; backspace on empty operand
        keys('{4'hC, 4'hD});
        cmp("bs empty", int'(operand_a), 0);
        keys('{4'h1, 4'h2, 4'h3, 4'h4, 4'h5});
        cmp("full operand_a", int'(operand_a), 'h1234);
        keys('{4'hD});
        cmp("bs operand_a", int'(operand_a), 'h0123);

        // 7,-,+,2,= then = again
        keys('{4'hC});
        go_seen = 0;
        keys('{4'h7, 4'hB, 4'hA, 4'h2, 4'hE});
        cmp("seq3 sub at go", sub_at_go, 0);
        cmp("seq3 go pulses", go_seen, 1);
        keys('{4'hE});
        cmp("seq3 repeat equals", go_seen, 1);
        cmp("seq3 display", int'(display), 'h0002);

        // Long hold, short glitch, short re-arm gap
        keys('{4'hC});
        press(4'h5, 100, GAP);
        cmp("long hold", int'(operand_a), 'h0005);
`ifdef KEYPAD_DEBOUNCE_EN
        press(4'h6, 10, GAP);
        cmp("glitch", int'(operand_a), 'h0005);
        press(4'h7, 30, 10);
        press(4'h7, 30, GAP);
        cmp("no re-arm", int'(operand_a), 'h0057);
`else
        press(4'h6, 1, GAP);
        cmp("short press", int'(operand_a), 'h0056);
`endif

        // Async reset in the middle of a held key
        keys('{4'hC, 4'h9, 4'hA, 4'h4});
        cmp("pre-reset operand_a", int'(operand_a), 'h0009);
        cmp("pre-reset operand_b", int'(operand_b), 'h0004);
        @(negedge clk);
        key_value = 4'h6;
        key_valid = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("async operand_a", int'(operand_a), 0);
        cmp("async operand_b", int'(operand_b), 0);
        cmp("async sub", int'(sub), 0);
        cmp("async go", int'(go), 0);
        cmp("async display", int'(display), 0);
        cmp("async state", int'(entry_state), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 10) @(negedge clk);
        cmp("held through reset", int'(operand_a), 0);
        key_valid = 1'b0;
        repeat (GAP) @(negedge clk);
        press(4'h6, HOLD, GAP);
        cmp("re-pressed", int'(operand_a), 'h0006);

        // Random key traffic, including presses shorter than the filter
        keys('{4'hC});
        for (int i = 0; i < 300; i++) begin
            press(4'($urandom_range(0, 15)), $urandom_range(1, N + 4), $urandom_range(1, N + 4));
        end
        repeat (GAP) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_operand_entry.md
KEYPAD_OPERAND_ENTRY -- requirements
Module: keypad_operand_entry

Interface
REQ-001 SHALL provide parameter DIGITS, default 4, giving the number of hex nibbles per operand.
REQ-002 SHALL provide parameter DEBOUNCE, default 16, giving the stable-cycle count used by debounce.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port key_value, input, 4 bits: key code from the keypad scanner.
REQ-006 SHALL have port key_valid, input, 1 bit: high while a key is held.
REQ-007 SHALL have port operand_a, output, DIGITS*4 bits: first operand.
REQ-008 SHALL have port operand_b, output, DIGITS*4 bits: second operand.
REQ-009 SHALL have port sub, output, 1 bit: 1 = subtract, 0 = add.
REQ-010 SHALL have port go, output, 1 bit: one-cycle pulse requesting the add/sub.
REQ-011 SHALL have port display, output, DIGITS*4 bits: the operand currently being shown.
REQ-012 SHALL have port entry_state, output, 2 bits: current FSM state code.

Function
REQ-013 SHALL convert each accepted key press into exactly one internal key strobe, regardless of hold time.
REQ-014 SHALL decode key codes as: 0x0-0x9 digit; 0xA plus; 0xB minus; 0xC clear; 0xD backspace; 0xE equals; 0xF ignored.
REQ-015 SHALL implement FSM states ENTER_A=0, ENTER_B=1, DONE=2; code 3 is unreachable and recovers to ENTER_A.
REQ-016 On a digit in ENTER_A or ENTER_B, SHALL shift the active operand left 4 bits, insert the digit at bits [3:0], and increment that operand's digit count.
REQ-017 SHALL ignore digits when the active digit count equals DIGITS (full); the operand is unchanged.
REQ-018 On backspace, SHALL shift the active operand right 4 bits with zero fill and decrement its count; backspace at count 0 is a no-op.
REQ-019 On plus/minus in ENTER_A, SHALL set sub (minus=1, plus=0), clear operand_b and its count, and go to ENTER_B.
REQ-020 On plus/minus in ENTER_B, SHALL update sub only; operands are unchanged.
REQ-021 On equals in ENTER_B, SHALL assert go for exactly the next cycle and go to DONE; equals in ENTER_A or DONE is ignored.
REQ-022 On a digit in DONE, SHALL clear both operands and counts, load the digit into operand_a with count 1, and go to ENTER_A.
REQ-023 On plus/minus in DONE, SHALL keep operand_a, clear operand_b, set sub, and go to ENTER_B.
REQ-024 On clear in any state, SHALL zero both operands, counts and sub, and go to ENTER_A.
REQ-025 SHALL drive display with operand_a in ENTER_A and with operand_b in ENTER_B and DONE.
REQ-026 SHALL change operand_a, operand_b, sub and display only on the clock edge that processes a key strobe.
REQ-027 The key strobe SHALL be processed one cycle after the debounced accept; total latency from accept to output is 1 clk.

Reset
REQ-028 While reset=0, SHALL force operand_a=0, operand_b=0, sub=0, go=0, display=0, entry_state=ENTER_A, debounce counter=0 and all digit counts=0, immediately and without a clock.
REQ-029 When reset and a key strobe occur in the same cycle, reset SHALL win; a key held across reset release SHALL NOT be accepted until it is released.

Configuration
REQ-030 With KEYPAD_DEBOUNCE_EN defined, SHALL accept a press only after key_valid stays high for DEBOUNCE consecutive cycles, and SHALL re-arm only after key_valid stays low for DEBOUNCE consecutive cycles.
REQ-031 Without KEYPAD_DEBOUNCE_EN, SHALL accept a press on each 0-to-1 transition of registered key_valid, with no counter.

Structure
REQ-032 The FSM state enum, key-code constants (KEY_PLUS ... KEY_EQUALS) and state codes SHALL live in shared package keypad_entry_pkg.
REQ-033 Press-acceptance logic, debounce and edge detect included, SHALL be one sub-module, key_debounce, that outputs a one-cycle strobe.

Verification
REQ-034 Bench SHALL press keys 1,2,A,3,E -> operand_a=0x0012, operand_b=0x0003, sub=0, go high for exactly 1 cycle, entry_state=DONE.
REQ-035 Bench SHALL press keys 1,2,3,4,5 -> operand_a=0x1234 (fifth digit ignored); then press D -> operand_a=0x0123.
REQ-036 Bench SHALL press keys 7,B,A,2,E -> sub=0 at go; press E again -> no second go pulse.
REQ-037 With KEYPAD_DEBOUNCE_EN and DEBOUNCE=16: hold key 5 for 100 cycles -> one digit entered; a 10-cycle glitch -> nothing entered; release for 10 cycles then press again -> second press ignored.
REQ-038 Bench SHALL enter 9,A,4, then assert reset mid-hold of key 6 -> all outputs 0 and entry_state=ENTER_A asynchronously; key 6 is not entered after reset release until it is re-pressed.
